// File: rtl/gray_conv_arbiter_pkg.sv
// Shared Gray-code definitions: default geometry and a reusable binary-to-Gray helper.
package gray_pkg;

  localparam int GRAY_W    = 4;
  localparam int GRAY_NREQ = 4;
  localparam int GRAY_FN_W = 32;

  // Callers zero-extend narrower values and truncate the result; the upper zeros leave the low bits exact.
  function automatic logic [GRAY_FN_W-1:0] bin_to_gray(input logic [GRAY_FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_conv_arbiter_rr.sv
// Round-robin arbiter core: owns the last winner and searches for the next requester after it.
module rr_arbiter_core
  import gray_pkg::*;
#(
  parameter int N_REQ = GRAY_NREQ,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             enable,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_id
);

  localparam logic [IDW-1:0] LAST_RST = IDW'(N_REQ - 1);

  logic [IDW-1:0]   last_id_r;
  logic [N_REQ-1:0] pick_s;
  logic [IDW-1:0]   pick_id_s;
  logic             found_s;

  // rotate-priority search starting just after the last winner
  always_comb begin
    int idx_v;
    idx_v     = 0;
    pick_s    = {N_REQ{1'b0}};
    pick_id_s = {IDW{1'b0}};
    found_s   = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx_v = int'(last_id_r) + i;
      if (idx_v >= N_REQ) begin
        idx_v = idx_v - N_REQ;
      end else begin
        idx_v = idx_v;
      end
      if (req[idx_v] && !found_s) begin
        pick_s[idx_v] = 1'b1;
        pick_id_s     = idx_v[IDW-1:0];
        found_s       = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign gnt    = (rst_n && enable) ? pick_s : {N_REQ{1'b0}};
  assign gnt_id = pick_id_s;

  // remember the winner only when its value is actually taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id_r <= LAST_RST;
    end else if (enable && found_s) begin
      last_id_r <= pick_id_s;
    end else begin
      last_id_r <= last_id_r;
    end
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Shares one binary-to-Gray converter among N_REQ requesters; single-entry tagged output
// register with valid/ready handshake and a wrapping conversion counter.
module gray_conv_arbiter
  import gray_pkg::*;
#(
  parameter int N_REQ = GRAY_NREQ,
  parameter int W     = GRAY_W,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] bin_in,
  output logic [N_REQ-1:0]   gnt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       gray_out,
  output logic [IDW-1:0]     out_id,
  output logic [15:0]        conv_count
);

  logic             enable_s;
  logic             accept_s;
  logic [IDW-1:0]   gnt_id_s;
  logic [W-1:0]     sel_bin_s;
  logic [W-1:0]     gray_s;
  logic             out_valid_r;
  logic [W-1:0]     gray_r;
  logic [IDW-1:0]   id_r;
  logic [15:0]      conv_count_r;

  // a slot is free when empty or being drained this cycle, so a pop and a load can overlap
  assign enable_s = !out_valid_r || out_ready;
  assign accept_s = (|req) && enable_s;

  rr_arbiter_core #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req),
    .enable (enable_s),
    .gnt    (gnt),
    .gnt_id (gnt_id_s)
  );

  // select the granted requester's slice
  always_comb begin
    sel_bin_s = {W{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      if (gnt_id_s == IDW'(k)) begin
        sel_bin_s = bin_in[k*W +: W];
      end else begin
        sel_bin_s = sel_bin_s;
      end
    end
  end

  assign gray_s = W'(bin_to_gray(GRAY_FN_W'(sel_bin_s)));

  // output slot: load on accept, empty on pop, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      gray_r      <= {W{1'b0}};
      id_r        <= {IDW{1'b0}};
    end else if (accept_s) begin
      out_valid_r <= 1'b1;
      gray_r      <= gray_s;
      id_r        <= gnt_id_s;
    end else if (out_ready && out_valid_r) begin
      out_valid_r <= 1'b0;
      gray_r      <= gray_r;
      id_r        <= id_r;
    end else begin
      out_valid_r <= out_valid_r;
      gray_r      <= gray_r;
      id_r        <= id_r;
    end
  end

  // count accepted conversions, wrapping naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conv_count_r <= 16'd0;
    end else if (accept_s) begin
      conv_count_r <= conv_count_r + 16'd1;
    end else begin
      conv_count_r <= conv_count_r;
    end
  end

  assign out_valid  = out_valid_r;
  assign gray_out   = gray_r;
  assign out_id     = id_r;
  assign conv_count = conv_count_r;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Scoreboard bench for gray_conv_arbiter: directed scenarios plus constrained-random traffic.
module tb_gray_conv_arbiter;

  localparam int N   = 4;
  localparam int W   = 4;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] bin_in = '0;
  logic           out_ready = 1'b1;
  logic [N-1:0]   gnt;
  logic           out_valid;
  logic [W-1:0]   gray_out;
  logic [IDW-1:0] out_id;
  logic [15:0]    conv_count;

  always #5 clk = ~clk;

  gray_conv_arbiter #(.N_REQ(N), .W(W), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .bin_in     (bin_in),
    .gnt        (gnt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .gray_out   (gray_out),
    .out_id     (out_id),
    .conv_count (conv_count)
  );

  typedef struct {
    int gray;
    int id;
    int cnt;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_last   = N - 1;
  int   m_cnt    = 0;
  bit   m_valid  = 1'b0;
  int   preload_seq  = 0;
  int   preload_seen = 0;
  bit   done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor + reference model: compares outputs against queued expectations, then predicts this cycle
  always @(negedge clk or negedge rst_n) begin
    int k;
    int b;
    logic [N-1:0] eg;
    k  = -1;
    b  = 0;
    eg = '0;
    if (!rst_n) begin
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_gray_out", {28'd0, gray_out}, 32'd0);
      chk("rst_out_id", {30'd0, out_id}, 32'd0);
      chk("rst_conv_count", {16'd0, conv_count}, 32'd0);
      chk("rst_gnt", {28'd0, gnt}, 32'd0);
      m_valid = 1'b0;
      m_last  = N - 1;
      m_cnt   = 0;
      sbq.delete();
    end else if (done) begin
      chk("sb_drained", sbq.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
    end else begin
      if (preload_seq != preload_seen) begin
        m_cnt = 65535;
        preload_seen = preload_seq;
      end
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) begin
        chk("sb_depth", sbq.size(), 32'd1);
        if (sbq.size() > 0) begin
          chk("gray_out", {28'd0, gray_out}, sbq[0].gray);
          chk("out_id", {30'd0, out_id}, sbq[0].id);
          chk("conv_count", {16'd0, conv_count}, sbq[0].cnt);
          if (out_ready) void'(sbq.pop_front());
        end
      end
      if ((req != '0) && (!m_valid || out_ready)) begin
        for (int i = 1; i <= N; i++) begin
          int c;
          c = (m_last + i) % N;
          if (k < 0 && req[c]) k = c;
        end
      end
      if (k >= 0) eg[k] = 1'b1;
      chk("gnt", {28'd0, gnt}, {28'd0, eg});
      if (k >= 0) begin
        b = int'(bin_in[k*W +: W]);
        m_cnt = (m_cnt + 1) % 65536;
        sbq.push_back('{gray: b ^ (b >> 1), id: k, cnt: m_cnt});
        m_last  = k;
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic drive(input logic [N-1:0] r, input logic [N*W-1:0] b, input logic rdy);
    @(posedge clk);
    #1;
    req       = r;
    bin_in    = b;
    out_ready = rdy;
  endtask

  // Stimulus only: never looks at expected values
  initial begin
    logic [N-1:0]   r;
    logic [N*W-1:0] bb;
    logic [N-1:0]   g;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1; req = 4'b0001; bin_in = 16'h000B; out_ready = 1'b1;
    drive(4'b0000, 16'h0000, 1'b1);
    drive(4'b0000, 16'h0000, 1'b1);
    for (int v = 0; v < 16; v++) drive(4'b0100, 16'(v) << 8, 1'b1);
    drive(4'b0000, 16'h0000, 1'b1);
    drive(4'b0000, 16'h0000, 1'b1);
    for (int i = 0; i < 6; i++) drive(4'b1111, 16'($urandom), 1'b1);
    for (int i = 0; i < 4; i++) drive(4'b1101, 16'($urandom), 1'b1);
    drive(4'b0000, 16'h0000, 1'b1);
    drive(4'b0000, 16'h0000, 1'b1);
    drive(4'b0001, 16'h0005, 1'b1);
    for (int i = 0; i < 3; i++) drive(4'b1111, 16'($urandom), 1'b0);
    drive(4'b1111, 16'($urandom), 1'b1);
    drive(4'b0000, 16'h0000, 1'b1);
    drive(4'b0000, 16'h0000, 1'b1);
    drive(4'b0100, 16'h0300, 1'b0);
    drive(4'b0100, 16'h0300, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0; req = 4'b1111; bin_in = 16'h9C36;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) drive(4'b1111, 16'($urandom), 1'b1);
    drive(4'b0000, 16'h0000, 1'b1);
    drive(4'b0000, 16'h0000, 1'b1);
    @(posedge clk);
    #1;
    force dut.conv_count_r = 16'hFFFF;
    preload_seq++;
    #1;
    release dut.conv_count_r;
    drive(4'b0010, 16'h00A0, 1'b1);
    drive(4'b0000, 16'h0000, 1'b1);
    drive(4'b0000, 16'h0000, 1'b1);
    r = '0; bb = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      g = gnt;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (g[k] || !r[k]) begin
          r[k] = ($urandom_range(0, 2) != 0);
          bb[k*W +: W] = W'($urandom);
        end
      end
      req = r; bin_in = bb; out_ready = ($urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 3; i++) drive(4'b0000, 16'h0000, 1'b1);
    done = 1'b1;
    repeat (20) @(posedge clk);
    $display("FAIL watchdog: summary not reached, actual running, required finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gray_conv_arbiter.md
# gray_conv_arbiter

Round-robin scheduler that shares one binary-to-Gray conversion datapath among N_REQ requesters. Each requester presents a W-bit binary value. The block grants one requester per cycle and converts that value to Gray code. The result goes into a single-entry output register, tagged with the requester index, under valid/ready backpressure. It sits between the code-conversion clients and any downstream consumer of Gray values.

## Interface
- N_REQ, default 4: number of requesters; must be ≥2.
- W, default 4: data width in bits.
- IDW, default $clog2(N_REQ): width of the requester tag.
- clk  in  1: single clock; all state updates on the rising edge.
- rst_n  in  1: reset, asynchronous, active-low.
- req  in  N_REQ: per-requester request level.
- bin_in  in  N_REQ*W: packed binary inputs; requester k occupies bits [k*W +: W].
- gnt  out  N_REQ: one-hot grant, combinational; the requester's value is taken this cycle.
- out_valid  out  1: output register holds a result.
- out_ready  in  1: consumer accepts the result this cycle.
- gray_out  out  W: Gray-coded result.
- out_id  out  IDW: index of the requester that produced gray_out.
- conv_count  out  16: number of conversions accepted; wraps modulo 2^16.

## Operation
- accept = (|req) && (!out_valid || out_ready).
- gnt is nonzero only when accept is high. At most one bit of gnt is set.
- Arbitration is round-robin.
  - The search starts at (last_id+1) mod N_REQ and takes the first k with req[k]=1.
  - last_id updates to the granted index only on accept.
- Conversion is gray = b ^ (b >> 1), where b is the granted requester's slice. gray[W-1] = b[W-1].
- Output register behaviour:
  - On accept: load gray_out and out_id, and set out_valid=1.
  - On out_ready && out_valid with no accept: clear out_valid.
  - Otherwise: hold.
- Simultaneous pop and accept in the same cycle:
  - The new result replaces the popped one.
  - out_valid stays 1.
  - There is no bubble.
- Stability under backpressure: while out_valid && !out_ready, gray_out and out_id do not change and gnt is 0.
- conv_count increments by 1 on every accept. It wraps from 0xFFFF to 0x0000.
- Requester contract: hold req and bin_in stable until gnt[k] is seen. A req dropped before grant is simply not served.
- Reset behaviour:
  - Outputs reset to: out_valid=0, gray_out=0, out_id=0, conv_count=0.
  - Internal state resets to last_id=N_REQ-1, so requester 0 has first priority.
  - gnt is 0 while rst_n=0.
- Reset mid-operation: any held result is discarded without handshake. Arbitration restarts from requester 0.

## Timing
- gnt is combinational from req, out_valid, out_ready and last_id in the same cycle.
- Latency: gnt in cycle t gives out_valid=1 with the result in cycle t+1.
- Throughput: one conversion per cycle while out_ready=1 and any req is high.
- Fairness: with all N_REQ requesting continuously and no backpressure, each requester is granted exactly once in every N_REQ consecutive grants.
- Backpressure stall: zero grants per stalled cycle. The first grant comes in the cycle that out_ready returns high.
- Reset deassertion: the first accept can occur in the first rising edge after rst_n rises.

## Structure
- Shared package gray_pkg:
  - localparam-style defaults GRAY_W=4 and GRAY_NREQ=4.
  - Function bin_to_gray(input logic [W-1:0]) for reuse by other Gray blocks.
- One sub-module, rr_arbiter_core (N_REQ):
  - Inputs: req, enable, clk, rst_n.
  - Outputs: one-hot gnt and the granted index.
  - Owns last_id and the rotate-priority logic.
- The top level holds the conversion mux, the output register and conv_count.

## Test plan
- Reset and single conversion:
  - Stimulus: reset asserted, then released; req=0001, bin_in[3:0]=1011, out_ready=1.
  - Response: gnt=0001 in the first cycle; next cycle out_valid=1, gray_out=1110, out_id=0, conv_count=1.
- Conversion sweep:
  - Stimulus: requester 2 alone, bin 0000…1111 over 16 cycles.
  - Response: outputs 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000; one per cycle; no gaps.
- Round-robin fairness:
  - Stimulus: req=1111 held, out_ready=1.
  - Response: grant sequence 0,1,2,3,0,1; after dropping req[1], sequence continues 2,3,0,2.
- Backpressure:
  - Stimulus: out_valid with gray_out=0111 from bin 0101; out_ready=0 for 3 cycles.
  - Response: gnt=0 and gray_out=0111 stable throughout. The cycle out_ready=1, the next grant fires and the next cycle shows the new value with no bubble.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously while out_valid=1 and last_id=2.
  - Response: out_valid, gray_out and conv_count go 0 immediately. After release with req=1111, the first grant is requester 0.
- Counter wrap:
  - Stimulus: force conv_count to 0xFFFF, then one accept.
  - Response: conv_count=0x0000. out_valid behaves normally.
